conv_window_ctrl: RTL and testbench

Write-side and read-address controller for the convolution line buffer. Accepts a raster-ordered pixel stream and writes it into the multi-port window BRAM, treated as a circular buffer of (KERNEL-1)*IMG_WIDTH+KERNEL entries. Each time a full KERNEL×KERNEL window is resident, it emits one read address per tap on the BRAM's parallel read ports. It also drives a window-valid strobe aligned to the BRAM's registered output, for the downstream MAC stage.

---
 rtl/conv_window_ctrl_pkg.sv | 24 ++
 rtl/conv_window_ctrl_ring_addr_sub.sv | 21 ++
 rtl/conv_window_ctrl.sv | 161 ++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_ctrl_pkg.sv
// Shared types and constants for the convolution line-buffer controller:
// FSM encodings, kernel default and the tap ordering the MAC stage also uses.
package conv_window_ctrl_pkg;

    localparam int KERNEL_DEF = 3;

    // Tap t = r*KERNEL + c; the MAC stage unpacks taps in the same order.
    localparam bit TAP_ROW_MAJOR = 1'b1;

    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Distance back from the bottom-right tap to tap (r,c) in raster order.
    function automatic int tap_offset(input int r, input int c, input int k, input int w);
        return (k - 1 - r) * w + (k - 1 - c);
    endfunction

endpackage

// File: rtl/conv_window_ctrl_ring_addr_sub.sv
// Combinational (a - b) mod RAM_DEPTH for one window tap; both operands
// must already be below RAM_DEPTH, so a single conditional add suffices.
module ring_addr_sub #(
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_DEPTH  = 21
) (
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [ADDR_WIDTH-1:0] b,
    output logic [ADDR_WIDTH-1:0] y
);

    logic [ADDR_WIDTH:0]   diff;
    logic [ADDR_WIDTH-1:0] wrapped;

    always_comb begin
        diff    = {1'b0, a} - {1'b0, b};
        wrapped = diff[ADDR_WIDTH-1:0] + ADDR_WIDTH'(RAM_DEPTH);
        y       = diff[ADDR_WIDTH] ? wrapped : diff[ADDR_WIDTH-1:0];
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Line-buffer write/read-address controller for the KxK convolution window.
// Define CONV_STRIDE2_EN to issue windows only on even offsets (stride 2).
module conv_window_ctrl
    import conv_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = 9,
    parameter int IMG_HEIGHT = 9,
    parameter int KERNEL     = KERNEL_DEF,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_DEPTH  = 21
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_valid,
    input  logic [DATA_WIDTH-1:0]               i_data,
    output logic                                o_ready,
    output logic                                o_wr_en,
    output logic [ADDR_WIDTH-1:0]               o_w_addrs,
    output logic [DATA_WIDTH-1:0]               o_w_data,
    output logic [ADDR_WIDTH*KERNEL*KERNEL-1:0] o_r_addrs,
    output logic                                o_win_valid,
    output logic                                o_frame_done
);

    localparam int TAPS   = KERNEL * KERNEL;
    localparam int CW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int STAGES = 2;

    localparam logic [CW-1:0]         COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]         COL_K     = CW'(KERNEL - 1);
    localparam logic [RW-1:0]         ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0]         ROW_K     = RW'(KERNEL - 1);
    localparam logic [ADDR_WIDTH-1:0] WPTR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    if (RAM_DEPTH != (KERNEL - 1) * IMG_WIDTH + KERNEL) begin : g_bad_depth
        $error("RAM_DEPTH must equal (KERNEL-1)*IMG_WIDTH+KERNEL");
    end

    state_t                              state;
    logic [ADDR_WIDTH-1:0]               wptr;
    logic [CW-1:0]                       col;
    logic [RW-1:0]                       row;
    logic [1:0]                          drain_cnt;
    logic                                done_pend;
    logic                                accept;
    logic                                win_now;
    logic                                at_fill_end;
    logic                                at_frame_end;
    logic [STAGES:0]                     vld_pipe;
    logic [TAPS-1:0][ADDR_WIDTH-1:0]     tap_addr;
    logic [TAPS-1:0][ADDR_WIDTH-1:0]     r_addrs_q;

    assign accept       = i_valid && o_ready;
    assign at_fill_end  = (row == ROW_K) && (col == COL_K);
    assign at_frame_end = (row == ROW_LAST) && (col == COL_LAST);

`ifdef CONV_STRIDE2_EN
    // Even distance from the first window position on both axes.
    assign win_now = accept && (row >= ROW_K) && (col >= COL_K) &&
                     (row[0] == ROW_K[0]) && (col[0] == COL_K[0]);
`else
    assign win_now = accept && (row >= ROW_K) && (col >= COL_K);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            o_ready      <= 1'b0;
            o_wr_en      <= 1'b0;
            o_w_addrs    <= '0;
            o_w_data     <= '0;
            o_frame_done <= 1'b0;
            wptr         <= '0;
            col          <= '0;
            row          <= '0;
            drain_cnt    <= '0;
            done_pend    <= 1'b0;
        end else begin
            o_wr_en      <= accept;
            o_frame_done <= done_pend;
            done_pend    <= 1'b0;
            if (accept) begin
                o_w_addrs <= wptr;
                o_w_data  <= i_data;
                wptr      <= (wptr == WPTR_LAST) ? '0 : wptr + ADDR_WIDTH'(1);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    o_ready <= 1'b1;
                    if (accept) state <= ST_FILL;
                end
                ST_FILL: begin
                    o_ready <= 1'b1;
                    if (accept && at_fill_end) state <= ST_RUN;
                end
                ST_RUN: begin
                    o_ready <= 1'b1;
                    if (accept && at_frame_end) begin
                        state     <= ST_DRAIN;
                        o_ready   <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Done pulse lands one cycle after the last window strobe.
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        state     <= ST_IDLE;
                        o_ready   <= 1'b1;
                        wptr      <= '0;
                        col       <= '0;
                        row       <= '0;
                        done_pend <= 1'b1;
                    end else begin
                        o_ready   <= 1'b0;
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Taps derive from the address just written; the oldest tap may alias
    // the next write, which the read-first BRAM resolves to the old pixel.
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        localparam int TR = TAP_ROW_MAJOR ? t / KERNEL : t % KERNEL;
        localparam int TC = TAP_ROW_MAJOR ? t % KERNEL : t / KERNEL;
        localparam logic [ADDR_WIDTH-1:0] OFF =
            ADDR_WIDTH'(tap_offset(TR, TC, KERNEL, IMG_WIDTH));
        ring_addr_sub #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .RAM_DEPTH  (RAM_DEPTH)
        ) u_ring (
            .a (o_w_addrs),
            .b (OFF),
            .y (tap_addr[t])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe  <= '0;
            r_addrs_q <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], win_now};
            if (vld_pipe[0]) r_addrs_q <= tap_addr;
        end
    end

    assign o_r_addrs   = r_addrs_q;
    assign o_win_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl with a read-first BRAM model.
module tb_conv_window_ctrl;

    localparam int W  = 9;
    localparam int H  = 9;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int D  = 21;
    localparam int NT = K * K;
`ifdef CONV_STRIDE2_EN
    localparam int EXP_WINS = 16;
`else
    localparam int EXP_WINS = 49;
`endif

    logic                i_clk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic                i_valid = 1'b0;
    logic [DW-1:0]       i_data = '0;
    logic                o_ready;
    logic                o_wr_en;
    logic [AW-1:0]       o_w_addrs;
    logic [DW-1:0]       o_w_data;
    logic [AW*NT-1:0]    o_r_addrs;
    logic                o_win_valid;
    logic                o_frame_done;

    conv_window_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K),
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(D)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_wr_en(o_wr_en), .o_w_addrs(o_w_addrs),
        .o_w_data(o_w_data), .o_r_addrs(o_r_addrs), .o_win_valid(o_win_valid),
        .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int                    cyc;
        int                    widx;
        logic [NT-1:0][AW-1:0] a;
        logic [NT-1:0][DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wins = 0;
    int   done_cnt = 0;
    int   frame_widx = 0;

    logic [DW-1:0]         mem [D];
    logic [NT-1:0][AW-1:0] ra_q;
    logic [NT-1:0][DW-1:0] rd_q;
    logic [NT-1:0][AW-1:0] first_taps;
    logic [NT-1:0][AW-1:0] second_taps;
    int FIRST_L[NT]  = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
    int SECOND_L[NT] = '{1, 2, 3, 10, 11, 12, 19, 20, 0};

    always @(posedge i_clk) cyc <= cyc + 1;

    // BRAM: registered read, read-before-write on a shared address.
    always @(posedge i_clk) begin
        for (int t = 0; t < NT; t++) begin
            ra_q[t] <= o_r_addrs[AW*t +: AW];
            rd_q[t] <= mem[o_r_addrs[AW*t +: AW]];
        end
        if (o_wr_en) mem[o_w_addrs] <= o_w_data;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t mon_e;
    int   mon_d;
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_win_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_window: got window at cycle %0d expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("win_cycle", cyc, mon_e.cyc);
                    chk("win_addrs", ra_q, mon_e.a);
                    chk("win_data", rd_q, mon_e.d);
                    if (mon_e.widx == 0) chk("first_taps", ra_q, first_taps);
`ifndef CONV_STRIDE2_EN
                    if (mon_e.widx == 1) chk("second_taps", ra_q, second_taps);
`endif
                    wins++;
                end
            end
            if (o_frame_done) begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done: got pulse at cycle %0d expected none", cyc);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_cycle", cyc, mon_d);
                    done_cnt++;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept.
    task automatic send_pixel(input int p, output int waited);
        exp_t e;
        int   row, col, q;
        bit   win;
        waited = 0;
        i_valid = 1'b1;
        i_data  = DW'(p);
        while (!o_ready && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no o_ready for pixel %0d expected accept", p);
        end else begin
            row = p / W;
            col = p % W;
            if (p == 0) frame_widx = 0;
            win = (row >= K - 1) && (col >= K - 1);
`ifdef CONV_STRIDE2_EN
            win = win && ((row - (K - 1)) % 2 == 0) && ((col - (K - 1)) % 2 == 0);
`endif
            if (win) begin
                e.cyc  = cyc + 3;
                e.widx = frame_widx;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++) begin
                        q = (row - (K - 1) + r) * W + (col - (K - 1) + c);
                        e.a[r*K+c] = AW'(q % D);
                        e.d[r*K+c] = DW'(q);
                    end
                exp_q.push_back(e);
                frame_widx++;
            end
            if (p == W * H - 1) done_q.push_back(cyc + 4);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic run_frame(input int gap, output int first_wait);
        int w;
        first_wait = 0;
        for (int p = 0; p < W * H; p++) begin
            send_pixel(p, w);
            if (p == 0) first_wait = w;
            repeat (gap) @(negedge i_clk);
        end
    endtask

    task automatic wait_done(input int target);
        int i = 0;
        while (done_cnt < target && i < 50) begin
            @(negedge i_clk);
            i++;
        end
        chk("frame_done_seen", done_cnt, target);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", o_ready, 0);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_w_addrs", o_w_addrs, 0);
        chk("rst_w_data", o_w_data, 0);
        chk("rst_r_addrs", o_r_addrs, 0);
        chk("rst_win_valid", o_win_valid, 0);
        chk("rst_frame_done", o_frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, fw, fw2, dummy;
        for (int t = 0; t < NT; t++) begin
            first_taps[t]  = AW'(FIRST_L[t]);
            second_taps[t] = AW'(SECOND_L[t]);
        end
        repeat (3) @(negedge i_clk);
        chk_reset_outputs();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("idle_ready", o_ready, 1);

        // Continuous frame
        w0 = wins;
        run_frame(0, fw);
        wait_done(1);
        chk("win_count_cont", wins - w0, EXP_WINS);

        // Valid toggling 1/0
        w0 = wins;
        run_frame(1, fw);
        wait_done(2);
        chk("win_count_gap", wins - w0, EXP_WINS);

        // Reset mid-frame after pixel 30, then restart
        for (int p = 0; p <= 30; p++) send_pixel(p, dummy);
        #2 i_rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        @(negedge i_clk);
        chk_reset_outputs();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        w0 = wins;
        run_frame(0, fw);
        wait_done(3);
        chk("win_count_rst", wins - w0, EXP_WINS);

        // Back-to-back frames
        w0 = wins;
        run_frame(0, fw);
        run_frame(0, fw2);
        chk("drain_ready_low", fw2, 2);
        wait_done(5);
        chk("win_count_b2b", wins - w0, 2 * EXP_WINS);

        repeat (5) @(negedge i_clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
